serial_full_adder: RTL and testbench



---
 rtl/serial_full_adder.sv | 91 +++++++++
 tb/tb_serial_full_adder.sv | 135 +++++++++++++
 2 files changed

// File: rtl/serial_full_adder.sv
// serial_full_adder: bit-serial A+B+cin, LSB first, one bit per clock; define SERIAL_FULL_ADDER_OVF_EN for a signed-overflow output ovf.
module serial_full_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
`ifdef SERIAL_FULL_ADDER_OVF_EN
  ,
  output logic             ovf
`endif
);
  localparam int CW = $clog2(WIDTH);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t           state_q;
  logic [WIDTH-1:0] a_q, b_q, acc_q, acc_d, sum_q;
  logic [CW-1:0]    cnt_q;
  logic             c_q, c_d, s_d, busy_q, done_q, cout_q, last_d;
`ifdef SERIAL_FULL_ADDER_OVF_EN
  logic             ovf_q;
  assign ovf = ovf_q;
`endif
  assign busy = busy_q;
  assign done = done_q;
  assign sum  = sum_q;
  assign cout = cout_q;
  always_comb begin
    s_d    = a_q[0] ^ b_q[0] ^ c_q;
    c_d    = (a_q[0] & b_q[0]) | (a_q[0] & c_q) | (b_q[0] & c_q);
    acc_d  = {s_d, acc_q[WIDTH-1:1]};
    last_d = cnt_q == CW'(WIDTH - 1);
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      sum_q   <= '0;
      cnt_q   <= '0;
      c_q     <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      cout_q  <= 1'b0;
`ifdef SERIAL_FULL_ADDER_OVF_EN
      ovf_q   <= 1'b0;
`endif
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE, DONE: begin
          state_q <= start ? RUN : IDLE;
          busy_q  <= start;
          if (start) begin
            a_q   <= a;
            b_q   <= b;
            c_q   <= cin;
            cnt_q <= '0;
            acc_q <= '0;
          end
        end
        RUN: begin
          a_q   <= a_q >> 1;
          b_q   <= b_q >> 1;
          c_q   <= c_d;
          acc_q <= acc_d;
          cnt_q <= cnt_q + CW'(1);
          if (last_d) begin
            sum_q   <= acc_d;
            cout_q  <= c_d;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= DONE;
`ifdef SERIAL_FULL_ADDER_OVF_EN
            // c_q is the carry into the MSB on this final step
            ovf_q   <= c_q ^ c_d;
`endif
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_serial_full_adder.sv
// tb_serial_full_adder: randomized self-checking bench against an arithmetic reference model.
module tb_serial_full_adder;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [7:0] a = '0, b = '0;
  logic       cin = 1'b0;
  logic       busy, done, cout;
  logic [7:0] sum;
`ifdef SERIAL_FULL_ADDER_OVF_EN
  logic       ovf;
`endif
  int pass_cnt = 0;
  int total = 0;

  serial_full_adder #(.WIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b), .cin(cin),
    .busy(busy), .done(done), .sum(sum), .cout(cout)
`ifdef SERIAL_FULL_ADDER_OVF_EN
    , .ovf(ovf)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    else pass_cnt++;
  endtask

  task automatic wait_done(output int lat, output int bc);
    lat = 0;
    bc = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      lat++;
      if (busy) bc++;
      if (done) break;
    end
  endtask

  task automatic check_result(input string tag, input logic [7:0] x, y, input logic ci);
    logic [8:0] exp;
    int s;
    exp = 9'(x) + 9'(y) + 9'(ci);
    s = int'($signed(x)) + int'($signed(y)) + int'(ci);
    check({tag, "_sum"}, 64'(sum), 64'(exp[7:0]));
    check({tag, "_cout"}, 64'(cout), 64'(exp[8]));
`ifdef SERIAL_FULL_ADDER_OVF_EN
    check({tag, "_ovf"}, 64'(ovf), 64'(s > 127 || s < -128));
`else
    if (s > 1000) $display("unexpected signed sum %0d", s);
`endif
  endtask

  task automatic op(input logic [7:0] x, y, input logic ci, input string tag, input bit timing);
    int lat, bc;
    @(negedge clk);
    a = x; b = y; cin = ci; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    a = 8'($urandom); b = 8'($urandom); cin = 1'($urandom);
    wait_done(lat, bc);
    if (timing) begin
      check({tag, "_lat"}, 64'(lat), 64'd9);
      check({tag, "_busy_cycles"}, 64'(bc), 64'd8);
    end else check({tag, "_done_seen"}, 64'(done), 64'd1);
    check_result(tag, x, y, ci);
    @(negedge clk);
    check({tag, "_done_pulse"}, 64'(done), 64'd0);
  endtask

  initial begin
    int lat, bc, dones;
    logic [7:0] m, y, x1, y1, x2, y2;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("reset_idle", {busy, done, cout, sum}, 64'd0);
    end
    op(8'h35, 8'h0A, 1'b0, "basic", 1'b1);
    op(8'hFF, 8'h01, 1'b1, "wrap", 1'b1);
    op(8'h7F, 8'h01, 1'b0, "sovf", 1'b1);
    op(8'h80, 8'h80, 1'b0, "negovf", 1'b0);
    op(8'h00, 8'h00, 1'b0, "zero", 1'b0);
    op(8'hFF, 8'hFF, 1'b1, "max", 1'b0);
    // back-to-back: start held through RUN and DONE with second operands
    x1 = 8'h5C; y1 = 8'hB3; x2 = 8'h21; y2 = 8'h9E;
    @(negedge clk);
    a = x1; b = y1; cin = 1'b1; start = 1'b1;
    @(posedge clk);
    #1 a = x2; b = y2; cin = 1'b0;
    wait_done(lat, bc);
    check("b2b_first_lat", 64'(lat), 64'd9);
    check_result("b2b_first", x1, y1, 1'b1);
    @(posedge clk);
    #1 start = 1'b0;
    wait_done(lat, bc);
    check("b2b_second_lat", 64'(lat), 64'd9);
    check("b2b_second_busy", 64'(bc), 64'd8);
    check_result("b2b_second", x2, y2, 1'b0);
    // asynchronous reset mid-run
    @(negedge clk);
    a = 8'h12; b = 8'h34; cin = 1'b0; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1 check("async_rst_clear", {busy, done, cout, sum}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    dones = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (done) dones++;
    end
    check("async_rst_no_done", 64'(dones), 64'd0);
    check("async_rst_idle", {busy, done, cout, sum}, 64'd0);
    op(8'hC4, 8'h5B, 1'b1, "post_rst", 1'b1);
    for (int i = 0; i < 30; i++)
      op(8'($urandom), 8'($urandom), 1'($urandom), "rand", 1'b0);
    // subtractor round-trip: diff + subtrahend reconstructs the minuend
    for (int i = 0; i < 200; i++) begin
      m = 8'($urandom);
      y = 8'($urandom);
      op(m - y, y, 1'b0, "roundtrip", 1'b0);
      check("roundtrip_minuend", 64'(sum), 64'(m));
      check("roundtrip_borrow", 64'(cout), 64'(m < y));
    end
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end
endmodule
